// File: rtl/sine_dac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sine_dac_sequencer
// Description : Frame scheduler for the sine-wave datapath. Each accepted tick
//               advances a phase accumulator, addresses a quarter-wave sine
//               ROM (with address mirroring), restores the sign of the ROM word
//               into an offset-binary sample and streams that sample MSB-first
//               to a serial DAC.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1          system clock
//   rst_n     in   1          synchronous reset, active low
//   en        in   1          1 = accept ticks
//   tick      in   1          one-cycle sample strobe
//   step      in   PHASE_W    phase increment per accepted tick
//   clr_ovr   in   1          clears the sticky overrun flag
//   rom_addr  out  ADDR_W     registered quarter-wave ROM address
//   rom_data  in   DATA_W     ROM word, valid ROM_LAT cycles after rom_addr
//   load      out  1          one-cycle pulse while the sample is captured
//   sample    out  DATA_W+1   last loaded sample, offset binary
//   cs_n      out  1          DAC chip select, low while shifting
//   SI_en     out  1          high for each valid SO bit
//   SO        out  1          serial data, MSB first
//   busy      out  1          high in every state except IDLE
//   overrun   out  1          sticky: tick arrived while busy
// ============================================================================
module sine_dac_sequencer #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tick,
  input  logic [PHASE_W-1:0] step,
  input  logic               clr_ovr,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               load,
  output logic [DATA_W:0]    sample,
  output logic               cs_n,
  output logic               SI_en,
  output logic               SO,
  output logic               busy,
  output logic               overrun
);

  // Counter shared by WAIT (ROM_LAT cycles) and SHIFT (DATA_W+1 cycles).
  localparam int c_CNT_MAX = (DATA_W + 1 > ROM_LAT) ? DATA_W + 1 : ROM_LAT;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'(ROM_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_SHIFT_LAST = c_CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [PHASE_W-1:0]   r_phase;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_neg;      // frame sample lies in the negative half-wave
  logic [DATA_W:0]      r_shreg;
  logic [ADDR_W-1:0]    r_rom_addr;
  logic [DATA_W:0]      r_sample;
  logic                 r_overrun;

  logic                 w_start;
  logic [1:0]           w_quad;
  logic [ADDR_W-1:0]    w_idx;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W:0]      w_sample;
  logic                 w_unused_phase;

  assign w_quad  = r_phase[PHASE_W-1 -: 2];
  assign w_idx   = r_phase[PHASE_W-3 -: ADDR_W];
  // Odd quadrants walk the quarter wave backwards.
  assign w_addr  = w_quad[0] ? ~w_idx : w_idx;
  // Negative half-wave: invert the magnitude below the mid-scale code.
  assign w_sample = r_neg ? {1'b0, ~rom_data} : {1'b1, rom_data};
  assign w_start  = (r_state == S_IDLE) && tick && en;

  // Fractional phase bits only carry the accumulator; they never address ROM.
  generate
    if (PHASE_W > ADDR_W + 2) begin : g_phase_lsb
      assign w_unused_phase = ^r_phase[PHASE_W-ADDR_W-3:0];
    end else begin : g_no_phase_lsb
      assign w_unused_phase = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    load   = 1'b0;
    cs_n   = 1'b1;
    SI_en  = 1'b0;
    SO     = 1'b0;
    busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == c_WAIT_LAST) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        load   = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        cs_n  = 1'b0;
        SI_en = 1'b1;
        SO    = r_shreg[DATA_W];
        if (r_cnt == c_SHIFT_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // rom_addr changes at the edge ending the tick cycle; a ROM of latency
  // ROM_LAT presents the word during the LOAD cycle, so the capture happens
  // on the edge that leaves LOAD and the first SO bit follows immediately.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_shreg    <= '0;
      r_rom_addr <= '0;
      r_sample   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_rom_addr <= w_addr;
            r_neg      <= w_quad[1];
            r_phase    <= r_phase + step;
          end
        end
        S_WAIT: begin
          if (r_cnt == c_WAIT_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_sample <= w_sample;
          r_shreg  <= w_sample;
          r_cnt    <= '0;
        end
        S_SHIFT: begin
          r_shreg <= {r_shreg[DATA_W-1:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Sticky overrun: a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (tick && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end else if (clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  assign rom_addr = r_rom_addr;
  assign sample   = r_sample;
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sine_dac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sine_dac_sequencer
// Description : Self-checking bench for sine_dac_sequencer (default params).
//               ROM model: rom_data = {rom_addr, 4'h0}, one cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_dac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        tick;
  logic [15:0] step;
  logic        clr_ovr;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic        load;
  logic [12:0] sample;
  logic        cs_n;
  logic        SI_en;
  logic        SO;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  sine_dac_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .tick     (tick),
    .step     (step),
    .clr_ovr  (clr_ovr),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .load     (load),
    .sample   (sample),
    .cs_n     (cs_n),
    .SI_en    (SI_en),
    .SO       (SO),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= {rom_addr, 4'h0};

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts a frame in the current cycle and observes it for 20 cycles.
  task automatic run_frame(input logic [15:0] stp, input logic drop_en,
                           output logic [7:0] a, output logic [12:0] smp,
                           output logic [12:0] bits, output int ncs, output int ld_at);
    tick = 1'b1; en = 1'b1; step = stp;
    @(negedge clk);
    tick = 1'b0;
    step = 16'hFFFF;            // must be ignored after the start edge
    if (drop_en) en = 1'b0;
    a = rom_addr; bits = '0; ncs = 0; ld_at = -1;
    for (int c = 1; c < 20; c++) begin
      if (load) ld_at = c;
      if (!cs_n) ncs++;
      if (SI_en) bits = {bits[11:0], SO};
      @(negedge clk);
    end
    smp = sample;
    en = 1'b1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] stp;
    logic        drop_en;
    logic [7:0]  exp_addr;
    logic [12:0] exp_sample;
  } vec_t;

  vec_t vecs[9];

  logic [7:0]  a;
  logic [12:0] smp;
  logic [12:0] bits;
  int          ncs;
  int          ld_at;
  logic [15:0] ph;
  logic [7:0]  ea;
  logic [11:0] er;
  logic [12:0] es;

  initial begin
    // Chain from phase 0; comments give the phase used by each frame.
    vecs[0] = '{16'h0040, 1'b0, 8'h00, 13'h1000}; // 0000 q0 idx00
    vecs[1] = '{16'h8000, 1'b0, 8'h01, 13'h1010}; // 0040 q0 idx01
    vecs[2] = '{16'h4000, 1'b1, 8'h01, 13'h0FEF}; // 8040 q2 idx01
    vecs[3] = '{16'h0000, 1'b0, 8'hFE, 13'h001F}; // C040 q3 ~01
    vecs[4] = '{16'h8000, 1'b0, 8'hFE, 13'h001F}; // C040 again (step 0)
    vecs[5] = '{16'hC000, 1'b0, 8'hFE, 13'h1FE0}; // 4040 q1 ~01
    vecs[6] = '{16'h7FC0, 1'b0, 8'h01, 13'h1010}; // 0040 (wrapped)
    vecs[7] = '{16'hC000, 1'b0, 8'h00, 13'h0FFF}; // 8000 q2 idx00
    vecs[8] = '{16'h0000, 1'b0, 8'hFF, 13'h1FF0}; // 4000 (wrapped) q1 ~00

    en = 1'b0; tick = 1'b0; step = '0; clr_ovr = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_cs_n", {15'd0, cs_n}, 16'd1);
    chk("rst_si_en", {15'd0, SI_en}, 16'd0);
    chk("rst_so", {15'd0, SO}, 16'd0);
    chk("rst_load", {15'd0, load}, 16'd0);
    chk("rst_addr", {8'd0, rom_addr}, 16'd0);
    chk("rst_sample", {3'd0, sample}, 16'd0);
    chk("rst_ovr", {15'd0, overrun}, 16'd0);

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].stp, vecs[i].drop_en, a, smp, bits, ncs, ld_at);
      chk($sformatf("v%0d_addr", i), {8'd0, a}, {8'd0, vecs[i].exp_addr});
      chk($sformatf("v%0d_sample", i), {3'd0, smp}, {3'd0, vecs[i].exp_sample});
      chk($sformatf("v%0d_bits", i), {3'd0, bits}, {3'd0, vecs[i].exp_sample});
      chk($sformatf("v%0d_cs_cycles", i), 16'(ncs), 16'd13);
      chk($sformatf("v%0d_load_at", i), 16'(ld_at), 16'd2);
      chk($sformatf("v%0d_ovr", i), {15'd0, overrun}, 16'd0);
    end

    // Reset in the middle of SHIFT
    tick = 1'b1; en = 1'b1; step = 16'h0000;
    cyc(1); tick = 1'b0;
    cyc(4);                                        // T+5, shifting
    chk("mid_cs_low", {15'd0, cs_n}, 16'd0);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_rst_cs_n", {15'd0, cs_n}, 16'd1);
    chk("mid_rst_si_en", {15'd0, SI_en}, 16'd0);
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_sample", {3'd0, sample}, 16'd0);
    run_frame(16'h0000, 1'b0, a, smp, bits, ncs, ld_at);
    chk("post_rst_addr", {8'd0, a}, 16'h0000);     // phase back to 0
    chk("post_rst_sample", {3'd0, smp}, 16'h1000);

    // Back-to-back tick, dropped ticks, overrun set/clear
    do_reset();
    tick = 1'b1; step = 16'h0040;                   // T
    cyc(1); tick = 1'b0;                            // T+1
    cyc(16);                                        // T+17
    chk("b2b_idle", {15'd0, busy}, 16'd0);
    tick = 1'b1; step = 16'h0000;
    cyc(1); tick = 1'b0;                            // T+18
    chk("b2b_busy", {15'd0, busy}, 16'd1);
    chk("b2b_ovr", {15'd0, overrun}, 16'd0);
    chk("b2b_addr", {8'd0, rom_addr}, 16'h0001);
    cyc(4);                                         // T+22 (frame +5)
    tick = 1'b1; step = 16'h1000;
    cyc(1); tick = 1'b0;                            // T+23
    chk("drop_ovr_set", {15'd0, overrun}, 16'd1);
    cyc(2);                                         // T+25
    tick = 1'b1; clr_ovr = 1'b1;
    cyc(1); tick = 1'b0;                            // T+26
    chk("set_wins", {15'd0, overrun}, 16'd1);
    cyc(1); clr_ovr = 1'b0;                         // T+27
    chk("ovr_clr", {15'd0, overrun}, 16'd0);
    cyc(7);                                         // T+34
    chk("frame2_end_idle", {15'd0, busy}, 16'd0);
    run_frame(16'h0000, 1'b0, a, smp, bits, ncs, ld_at);
    chk("drop_no_advance", {8'd0, a}, 16'h0001);
    chk("drop_no_advance_smp", {3'd0, smp}, 16'h1010);

    // Tick with en low is ignored
    tick = 1'b1; en = 1'b0;
    cyc(1); tick = 1'b0;
    chk("en0_busy", {15'd0, busy}, 16'd0);
    chk("en0_ovr", {15'd0, overrun}, 16'd0);
    chk("en0_cs_n", {15'd0, cs_n}, 16'd1);
    en = 1'b1;

    // 257 ticks of step 0x40 through a full quarter into q1
    do_reset();
    ph = 16'h0000;
    for (int k = 1; k <= 257; k++) begin
      run_frame(16'h0040, 1'b0, a, smp, bits, ncs, ld_at);
      ea = ph[14] ? ~ph[13:6] : ph[13:6];
      er = {ea, 4'h0};
      es = ph[15] ? {1'b0, ~er} : {1'b1, er};
      if (k % 32 == 0 || k >= 255) begin
        chk($sformatf("sweep%0d_addr", k), {8'd0, a}, {8'd0, ea});
        chk($sformatf("sweep%0d_smp", k), {3'd0, smp}, {3'd0, es});
      end
      if (k == 256) chk("sweep256_ff", {8'd0, a}, 16'h00FF);
      if (k == 257) begin
        chk("sweep257_ff", {8'd0, a}, 16'h00FF);
        chk("sweep257_smp", {3'd0, smp}, 16'h1FF0);
      end
      ph = ph + 16'h0040;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
